// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: round-robin sequencer sharing one APB bridge command port
// between NREQ requesters. One command is in flight at a time. Read data and
// error are returned only to the granted requester.
// Ports:
//   PCLK, PRESET        clock (posedge), asynchronous active-high reset
//   req_valid/req_write per-requester command valid and direction (1 = write)
//   req_addr/req_wdata  packed per-requester address / write data
//   req_ready           one-hot pulse, command captured
//   rsp_valid           one-hot pulse, transfer finished
//   rsp_rdata/rsp_err   response data / error, valid with rsp_valid
//   transfer, READ_WRITE, apb_write_paddr, apb_read_paddr, apb_write_data
//                       command to the bridge
//   apb_read_data_out, PSLVERR, xfer_done
//                       completion from the bridge
module apb_req_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned ADDR_W  = 9,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                     PCLK,
    input  logic                     PRESET,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ-1:0]          req_write,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_wdata,
    output logic [NREQ-1:0]          req_ready,
    output logic [NREQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]        rsp_rdata,
    output logic                     rsp_err,
    output logic                     transfer,
    output logic                     READ_WRITE,
    output logic [ADDR_W-1:0]        apb_write_paddr,
    output logic [ADDR_W-1:0]        apb_read_paddr,
    output logic [DATA_W-1:0]        apb_write_data,
    input  logic [DATA_W-1:0]        apb_read_data_out,
    input  logic                     PSLVERR,
    input  logic                     xfer_done
);

    localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [NREQ-1:0]    req_ready_d, rsp_valid_d;
    logic [DATA_W-1:0]  rsp_rdata_d;
    logic               rsp_err_d, transfer_d, rw_d;
    logic [ADDR_W-1:0]  wpaddr_d, rpaddr_d;
    logic [DATA_W-1:0]  wdata_d;

    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    logic [IDX_W-1:0]   cand;

    // Round-robin pick: first valid requester after the last granted one
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = IDX_W'((32'(ptr_q) + k) % NREQ);
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        req_ready_d = '0;
        rsp_valid_d = '0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        transfer_d  = transfer;
        rw_d        = READ_WRITE;
        wpaddr_d    = apb_write_paddr;
        rpaddr_d    = apb_read_paddr;
        wdata_d     = apb_write_data;

        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    idx_d       = win_idx;
                    ptr_d       = win_idx;
                    req_ready_d = NREQ'(1) << win_idx;
                    transfer_d  = 1'b1;
                    rw_d        = ~req_write[win_idx];
                    cnt_d       = '0;
                    state_d     = S_WAIT;
                    // Unused direction's address/data are forced to zero
                    if (req_write[win_idx]) begin
                        wpaddr_d = req_addr[32'(win_idx) * ADDR_W +: ADDR_W];
                        wdata_d  = req_wdata[32'(win_idx) * DATA_W +: DATA_W];
                        rpaddr_d = '0;
                    end else begin
                        wpaddr_d = '0;
                        wdata_d  = '0;
                        rpaddr_d = req_addr[32'(win_idx) * ADDR_W +: ADDR_W];
                    end
                end
            end
            S_WAIT: begin
                if (TIMEOUT != 0 && cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
                // Completion takes precedence over a coincident timeout
                if (xfer_done) begin
                    transfer_d         = 1'b0;
                    rsp_rdata_d        = READ_WRITE ? apb_read_data_out : '0;
                    rsp_err_d          = PSLVERR;
                    rsp_valid_d[idx_q] = 1'b1;
                    state_d            = S_RESP;
                end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
                    transfer_d         = 1'b0;
                    rsp_err_d          = 1'b1;
                    rsp_valid_d[idx_q] = 1'b1;
                    state_d            = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q         <= S_IDLE;
            idx_q           <= '0;
            ptr_q           <= IDX_W'(NREQ - 1);
            cnt_q           <= '0;
            req_ready       <= '0;
            rsp_valid       <= '0;
            rsp_rdata       <= '0;
            rsp_err         <= 1'b0;
            transfer        <= 1'b0;
            READ_WRITE      <= 1'b0;
            apb_write_paddr <= '0;
            apb_read_paddr  <= '0;
            apb_write_data  <= '0;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            ptr_q           <= ptr_d;
            cnt_q           <= cnt_d;
            req_ready       <= req_ready_d;
            rsp_valid       <= rsp_valid_d;
            rsp_rdata       <= rsp_rdata_d;
            rsp_err         <= rsp_err_d;
            transfer        <= transfer_d;
            READ_WRITE      <= rw_d;
            apb_write_paddr <= wpaddr_d;
            apb_read_paddr  <= rpaddr_d;
            apb_write_data  <= wdata_d;
        end
    end

endmodule
